// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA boss-fight pipeline.
//   - Boss sprite geometry (BOSS_LNG / BOSS_HGT).
//   - Default combat tuning for boss_hit_ctrl (hit points, per-weapon
//     damage, invulnerability and flash durations in frames).
//   - Widths of the HP register and the frame timers.
//   - Boss controller state enum.
// ---------------------------------------------------------------------------
package vga_pkg;

  // Boss sprite size in pixels
  localparam int BOSS_LNG = 64;
  localparam int BOSS_HGT = 64;

  // Default combat tuning; boss_hit_ctrl parameters take these as defaults
  localparam int DEF_BOSS_MAX_HP   = 100;
  localparam int DEF_MELEE_DMG     = 5;
  localparam int DEF_ARCHER_DMG    = 3;
  localparam int DEF_INVULN_FRAMES = 30;
  localparam int DEF_FLASH_FRAMES  = 8;

  // Width of the HP register and of the frame down-counters
  localparam int HP_W  = 8;
  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALIVE    = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_DEAD     = 2'd3
  } boss_state_e;

endpackage

// File: rtl/boss_frame_timer.sv
// ---------------------------------------------------------------------------
// boss_frame_timer
// Loadable down-counter that decrements once per frame tick and stops at 0.
//
// Ports
//   i_clk       : clock
//   i_rst_n     : asynchronous active-low reset (count -> 0)
//   i_clr       : synchronous clear (highest priority)
//   i_load      : load i_load_val (beats a coincident tick)
//   i_load_val  : value to load
//   i_tick      : frame tick, decrements a non-zero count
//   o_zero      : count is currently 0
//   o_expire    : count is 1 and this tick takes it to 0 at the next edge
// ---------------------------------------------------------------------------
module boss_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_zero,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

  // Lets the owner update its registered outputs on the same edge the
  // count lands on zero, instead of one cycle later.
  assign o_expire = i_tick && !i_clr && !i_load && (r_count == CNT_W'(1));

endmodule

// File: rtl/boss_hit_ctrl.sv
// ---------------------------------------------------------------------------
// boss_hit_ctrl
// Boss hit-point controller. Collects per-pixel overlap pulses from the
// melee and archer stages during a frame, applies at most one hit per frame
// (melee wins over archer) on frame_tick, then holds the boss invulnerable
// for INVULN_FRAMES frames with a FLASH_FRAMES sprite tint.
//
// Ports
//   clk           : clock
//   rst_n         : asynchronous active-low reset, deassertion synchronised
//   frame_tick    : one-cycle pulse at vsync start
//   game_active   : non-zero while a fight is running
//   melee_hit     : weapon sprite overlap pulse
//   archer_hit    : projectile overlap pulse
//   boss_alive    : boss drawable and hittable (ALIVE / COOLDOWN)
//   boss_hp       : current hit points
//   hit_flash     : sprite tint request after an accepted hit
//   boss_defeated : one-cycle pulse when HP reaches 0
// All outputs are registered.
// ---------------------------------------------------------------------------
module boss_hit_ctrl
  import vga_pkg::*;
#(
  parameter int BOSS_MAX_HP   = DEF_BOSS_MAX_HP,
  parameter int MELEE_DMG     = DEF_MELEE_DMG,
  parameter int ARCHER_DMG    = DEF_ARCHER_DMG,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int FLASH_FRAMES  = DEF_FLASH_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] game_active,
  input  logic       melee_hit,
  input  logic       archer_hit,
  output logic       boss_alive,
  output logic [7:0] boss_hp,
  output logic       hit_flash,
  output logic       boss_defeated
);

  localparam logic [HP_W-1:0]  MAX_HP_V  = HP_W'(BOSS_MAX_HP);
  localparam logic [HP_W-1:0]  MELEE_V   = HP_W'(MELEE_DMG);
  localparam logic [HP_W-1:0]  ARCHER_V  = HP_W'(ARCHER_DMG);
  localparam logic [TMR_W-1:0] INVULN_V  = TMR_W'(INVULN_FRAMES);
  localparam logic [TMR_W-1:0] FLASH_V   = TMR_W'(FLASH_FRAMES);

  // Damage never wraps below zero
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  boss_state_e     r_state;
  boss_state_e     w_state_nxt;

  logic [1:0]      r_rst_sync;
  logic            r_melee_pend;
  logic            r_archer_pend;
  logic [HP_W-1:0] r_hp;
  logic            r_alive;
  logic            r_flash;
  logic            r_defeated;

  logic            w_active;
  logic            w_start;
  logic            w_hit_apply;
  logic [HP_W-1:0] w_dmg;
  logic [HP_W-1:0] w_hp_hit;

  logic [HP_W-1:0] w_hp_nxt;
  logic            w_alive_nxt;
  logic            w_flash_nxt;
  logic            w_def_nxt;
  logic            w_mpend_nxt;
  logic            w_apend_nxt;
  logic            w_tmr_load;
  logic            w_tmr_clr;
  logic            w_tmr_tick;

  logic            w_inv_zero;
  logic            w_inv_expire;
  logic            w_fl_zero;
  logic            w_fl_expire;

  // Reset release is re-timed to clk; assertion still clears it at once,
  // so the FSM cannot leave IDLE until two clean edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_active    = |game_active;
  assign w_start     = frame_tick && r_rst_sync[1];
  assign w_hit_apply = (r_state == ST_ALIVE) && frame_tick &&
                       (r_melee_pend || r_archer_pend);
  assign w_dmg       = r_melee_pend ? MELEE_V : ARCHER_V;
  assign w_hp_hit    = sat_sub(r_hp, w_dmg);
  assign w_tmr_tick  = frame_tick && (r_state == ST_COOLDOWN);

  boss_frame_timer #(
    .CNT_W (TMR_W)
  ) u_invuln_tmr (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (INVULN_V),
    .i_tick     (w_tmr_tick),
    .o_zero     (w_inv_zero),
    .o_expire   (w_inv_expire)
  );

  boss_frame_timer #(
    .CNT_W (TMR_W)
  ) u_flash_tmr (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (FLASH_V),
    .i_tick     (w_tmr_tick),
    .o_zero     (w_fl_zero),
    .o_expire   (w_fl_expire)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; losing game_active overrides every state
  always_comb begin
    w_state_nxt = r_state;
    if (!w_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) w_state_nxt = ST_ALIVE;
        end
        ST_ALIVE: begin
          if (w_hit_apply) begin
            w_state_nxt = (w_hp_hit == '0) ? ST_DEAD : ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (w_inv_expire || w_inv_zero) w_state_nxt = ST_ALIVE;
        end
        ST_DEAD: begin
          w_state_nxt = ST_DEAD;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: next values for the registered outputs, pend flags and
  // timer controls. Pend flags default to clear, so they only survive
  // while ALIVE and outside a frame_tick.
  always_comb begin
    w_hp_nxt    = r_hp;
    w_flash_nxt = r_flash;
    w_def_nxt   = 1'b0;
    w_mpend_nxt = 1'b0;
    w_apend_nxt = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_clr   = 1'b0;
    if (!w_active) begin
      w_flash_nxt = 1'b0;
      w_tmr_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) w_hp_nxt = MAX_HP_V;
        end
        ST_ALIVE: begin
          if (w_hit_apply) begin
            w_hp_nxt = w_hp_hit;
            if (w_hp_hit == '0) begin
              w_def_nxt = 1'b1;
            end else begin
              w_tmr_load  = 1'b1;
              w_flash_nxt = 1'b1;
            end
          end else if (frame_tick) begin
            // Hits landing on the tick itself belong to the next frame
            w_mpend_nxt = melee_hit;
            w_apend_nxt = archer_hit;
          end else begin
            w_mpend_nxt = r_melee_pend  | melee_hit;
            w_apend_nxt = r_archer_pend | archer_hit;
          end
        end
        ST_COOLDOWN: begin
          if (w_fl_expire || w_fl_zero) w_flash_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
    w_alive_nxt = (w_state_nxt == ST_ALIVE) || (w_state_nxt == ST_COOLDOWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp          <= MAX_HP_V;
      r_alive       <= 1'b0;
      r_flash       <= 1'b0;
      r_defeated    <= 1'b0;
      r_melee_pend  <= 1'b0;
      r_archer_pend <= 1'b0;
    end else begin
      r_hp          <= w_hp_nxt;
      r_alive       <= w_alive_nxt;
      r_flash       <= w_flash_nxt;
      r_defeated    <= w_def_nxt;
      r_melee_pend  <= w_mpend_nxt;
      r_archer_pend <= w_apend_nxt;
    end
  end

  assign boss_hp       = r_hp;
  assign boss_alive    = r_alive;
  assign hit_flash     = r_flash;
  assign boss_defeated = r_defeated;

endmodule

// File: tb/tb_boss_hit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boss_hit_ctrl
// Frame-level reference model with a time-stamped expectation queue. The
// driver issues frames (tick cycle + hit cycles), updates the model and
// queues the outputs expected after each tick; the monitor pops and
// compares on the falling edge of the stamped cycle.
// ---------------------------------------------------------------------------
module tb_boss_hit_ctrl;

  localparam int MAX_HP = 100;
  localparam int MELEE  = 5;
  localparam int ARCHER = 3;
  localparam int INVULN = 30;
  localparam int FLASH  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] game_active = 2'd0;
  logic       melee_hit = 1'b0;
  logic       archer_hit = 1'b0;
  logic       boss_alive;
  logic [7:0] boss_hp;
  logic       hit_flash;
  logic       boss_defeated;

  boss_hit_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .game_active   (game_active),
    .melee_hit     (melee_hit),
    .archer_hit    (archer_hit),
    .boss_alive    (boss_alive),
    .boss_hp       (boss_hp),
    .hit_flash     (hit_flash),
    .boss_defeated (boss_defeated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    hp;
    bit    alive;
    bit    flash;
    bit    defeated;
    string tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: fight status, HP, frames of invulnerability and
  // flash still owed, and hits gathered while the boss is hittable.
  bit   m_started, m_dead, m_pm, m_pa;
  int   m_hp = MAX_HP;
  int   m_inv, m_fl;
  bit [1:0] ga = 2'd1;

  task automatic check(input string tag, input string fld, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s.%s cycle=%0d got=%0d expected=%0d", tag, fld, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc) begin
        check(e.tag, "missed_slot", cyc, e.at);
      end else begin
        check(e.tag, "hp",       int'(boss_hp),       e.hp);
        check(e.tag, "alive",    int'(boss_alive),    int'(e.alive));
        check(e.tag, "flash",    int'(hit_flash),     int'(e.flash));
        check(e.tag, "defeated", int'(boss_defeated), int'(e.defeated));
      end
    end
  end

  task automatic expect_at(input int at, input bit defeated, input string tag);
    exp_t e;
    e.at       = at;
    e.hp       = m_hp;
    e.alive    = m_started && !m_dead;
    e.flash    = (m_fl > 0);
    e.defeated = defeated;
    e.tag      = tag;
    q.push_back(e);
  endtask

  task automatic model_clear();
    m_started = 1'b0;
    m_dead    = 1'b0;
    m_inv     = 0;
    m_fl      = 0;
    m_pm      = 1'b0;
    m_pa      = 1'b0;
  endtask

  // One frame boundary: start a fight, count down invulnerability, or
  // resolve the hit gathered over the previous frame.
  task automatic model_tick(input bit tm, input bit ta, output bit died);
    int dmg;
    died = 1'b0;
    if (!m_started) begin
      model_clear();
      m_started = 1'b1;
      m_hp      = MAX_HP;
    end else if (m_dead) begin
      m_pm = 1'b0;
      m_pa = 1'b0;
    end else if (m_inv > 0) begin
      m_inv--;
      if (m_fl > 0) m_fl--;
      m_pm = 1'b0;
      m_pa = 1'b0;
    end else if (m_pm || m_pa) begin
      dmg  = m_pm ? MELEE : ARCHER;
      m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
      m_pm = 1'b0;
      m_pa = 1'b0;
      if (m_hp == 0) begin
        m_dead = 1'b1;
        died   = 1'b1;
      end else begin
        m_inv = INVULN;
        m_fl  = FLASH;
      end
    end else begin
      m_pm = tm;
      m_pa = ta;
    end
  endtask

  task automatic model_hit(input bit m, input bit a);
    if (m_started && !m_dead && m_inv == 0) begin
      m_pm = m_pm | m;
      m_pa = m_pa | a;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A frame of len cycles: tick (with optional coincident hits) then
  // len-1 cycles of hits with the given per-cycle percentages.
  task automatic frame(input int len, input int mp, input int ap,
                       input bit tm, input bit ta, input string tag);
    bit died, m, a;
    step();
    game_active = ga;
    frame_tick  = 1'b1;
    melee_hit   = tm;
    archer_hit  = ta;
    model_tick(tm, ta, died);
    expect_at(cyc + 1, died, tag);
    expect_at(cyc + 2, 1'b0, tag);
    for (int i = 1; i < len; i++) begin
      step();
      frame_tick = 1'b0;
      m = (int'($urandom_range(0, 99)) < mp);
      a = (int'($urandom_range(0, 99)) < ap);
      melee_hit  = m;
      archer_hit = a;
      model_hit(m, a);
    end
  endtask

  task automatic drop_game(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      game_active = 2'd0;
      frame_tick  = 1'b0;
      melee_hit   = 1'($urandom_range(0, 1));
      archer_hit  = 1'($urandom_range(0, 1));
      if (i == 0) begin
        model_clear();
        expect_at(cyc + 1, 1'b0, "drop");
      end
    end
    ga = 2'($urandom_range(1, 3));
  endtask

  // Reset is sampled on the falling edge of the cycle it is asserted in,
  // before any rising edge, so the values must appear asynchronously.
  task automatic do_reset();
    step();
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    melee_hit  = 1'b0;
    archer_hit = 1'b0;
    model_clear();
    m_hp = MAX_HP;
    expect_at(cyc, 1'b0, "reset_async");
    expect_at(cyc + 1, 1'b0, "reset_held");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic cool_out();
    repeat (INVULN - 1) frame(4, 50, 50, 1'b1, 1'b1, "cooldown");
    frame(4, 0, 0, 1'b0, 1'b0, "cool_end");
  endtask

  task automatic hit(input bit melee, input string tag);
    frame(4, melee ? 100 : 0, melee ? 0 : 100, 1'b0, 1'b0, tag);
    frame(4, 0, 0, 1'b0, 1'b0, tag);
    cool_out();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    do_reset();

    // Idle fight: three quiet frames
    ga = 2'd1;
    repeat (3) frame(6, 0, 0, 1'b0, 1'b0, "t1_quiet");

    // 50 melee pulses in one frame -> a single hit, then invulnerability
    frame(51, 100, 0, 1'b0, 1'b0, "t2_burst");
    frame(6, 0, 0, 1'b0, 1'b0, "t2_apply");
    repeat (INVULN - 1) frame(6, 100, 100, 1'b1, 1'b1, "t2_invuln");
    frame(6, 0, 0, 1'b1, 1'b0, "t2_last_invuln");
    frame(6, 0, 0, 1'b0, 1'b0, "t2_after");

    // Melee and archer in one frame: melee damage only
    frame(6, 100, 100, 1'b0, 1'b0, "t3_both");
    frame(6, 0, 0, 1'b0, 1'b0, "t3_apply");
    cool_out();

    // Hit coincident with the tick counts toward the next frame
    frame(6, 0, 0, 1'b1, 1'b0, "t5_on_tick");
    frame(6, 0, 0, 1'b0, 1'b0, "t5_next");
    cool_out();

    // Grind down to 4, archer to 1, then the killing blow and DEAD hold
    repeat (15) hit(1'b1, "t4_grind_m");
    repeat (2)  hit(1'b0, "t4_grind_a");
    hit(1'b0, "t4_hp4_archer");
    hit(1'b1, "t4_hp1_melee");
    repeat (4) frame(6, 80, 80, 1'b1, 1'b1, "t4_dead_hold");
    drop_game(3);

    // New fight: grind to 2, then melee saturates to 0
    frame(6, 0, 0, 1'b0, 1'b0, "t6_fresh");
    repeat (19) hit(1'b1, "t4b_grind_m");
    hit(1'b0, "t4b_grind_a");
    hit(1'b1, "t4b_hp2_melee");
    repeat (3) frame(6, 60, 60, 1'b0, 1'b0, "t4b_dead_hold");
    drop_game(2);

    // Reset mid-cooldown with 12 invulnerable frames left
    frame(6, 0, 0, 1'b0, 1'b0, "t6_start");
    frame(6, 100, 0, 1'b0, 1'b0, "t6_hit");
    frame(6, 0, 0, 1'b0, 1'b0, "t6_apply");
    repeat (INVULN - 12) frame(6, 30, 30, 1'b0, 1'b0, "t6_cool");
    do_reset();
    frame(6, 0, 0, 1'b0, 1'b0, "t6_after_reset");
    hit(1'b0, "t6_restart_hit");

    // Randomised play with occasional drops of game_active
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        drop_game(int'($urandom_range(2, 4)));
      end else begin
        frame(int'($urandom_range(3, 8)), int'($urandom_range(0, 30)),
              int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), "rand");
      end
    end

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
